// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches to instruction memory,
// buffers in-order responses with their PCs, presents the head to the decoder,
// and handles redirects by flushing and draining stale responses.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     buf_data [BUF_DEPTH];
  logic [31:0]     buf_pc   [BUF_DEPTH];
  logic            resp_ok, push, pop;
  logic [CW:0]     in_flight;
  logic [31:0]     resp_pc;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = imem_valid && (outstanding != '0);

  // Requests in flight while in FETCH were issued from contiguous PCs ending
  // at pc-4 (FETCH is only entered with nothing outstanding), so the oldest
  // one, which this response answers, sits at pc - 4*outstanding.
  assign resp_pc = pc - {{(30-CW){1'b0}}, outstanding, 2'b00};

  // A same-cycle pop frees a slot, so it counts against the budget; this
  // keeps a 1-cycle memory streaming one instruction per cycle.
  assign in_flight = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};

  assign outstanding_nxt = outstanding + {{(CW-1){1'b0}}, imem_req}
                                       - {{(CW-1){1'b0}}, resp_ok};

  assign imem_addr = pc;
  assign instr     = buf_data[rd_ptr];
  assign instr_pc  = buf_pc[rd_ptr];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: redirect drains stale responses if any remain in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH, DRAIN: begin
        if (redirect)
          state_nxt = (outstanding_nxt != '0) ? DRAIN : FETCH;
        else if (state == DRAIN && outstanding_nxt == '0)
          state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and buffer handshakes derived from the current state
  always_comb begin
    instr_valid = (state == FETCH) && (count != '0);
    pop         = instr_valid && !stall && !redirect;
    push        = resp_ok && (state == FETCH) && !redirect;
    imem_req    = (state == FETCH) && !redirect && (in_flight < DEPTH_W);
  end

  // PC and outstanding-request counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect)      pc <= redirect_pc;
      else if (imem_req) pc <= pc + 32'd4;
    end
  end

  // Instruction buffer: circular FIFO of {instr, pc}, flushed on redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]   <= resp_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule
